morse_tx_ctrl: RTL

Sequencing controller for the Morse output path. Accepts 3-bit letter codes (S..Z) from a requester over a valid/ready handshake and queues them in a small FIFO. Each letter is expanded into its 14-bit Morse pattern and shifted out MSB first, one bit per tick from an internal down-counting rate divider, with a fixed zero gap between letters. Sits between the switch/key front end and the LED driving `morse_out`.

---
 rtl/morse_tx_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/morse_tx_ctrl.sv
// morse_tx_ctrl: queues S..Z letter codes and shifts their 14-bit Morse patterns out MSB first,
// one bit every TICK_COUNT cycles, followed by GAP_BITS zero periods. Define MORSE_TX_ABORT_EN for the abort input.
module morse_tx_ctrl #(
  parameter int TICK_COUNT = 25000000,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_BITS   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic [2:0] req_letter,
  output logic       req_ready,
  output logic       morse_out,
  output logic       busy,
  output logic       letter_done
`ifdef MORSE_TX_ABORT_EN
  ,
  input  logic       abort
`endif
);
  localparam int CW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
  localparam logic [CW-1:0] TICK_RELOAD = CW'(TICK_COUNT - 1);
  localparam logic [AW:0]   COUNT_FULL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LOAD    = GW'(GAP_BITS);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} state_t;

  state_t          r_state;
  logic [13:0]     r_shift;
  logic [3:0]      r_bit_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic [CW-1:0]   r_tick_cnt;
  logic [2:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic            w_abort;
  logic            w_tick;
  logic            w_push;
  logic            w_pop;
  logic            w_fifo_nonempty;
  logic            w_last_bit;
  logic            w_last_gap;
  logic [2:0]      w_head;

`ifdef MORSE_TX_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  function automatic logic [13:0] pattern_of(input logic [2:0] letter);
    logic [13:0] p;
    p = '0;
    case (letter)
      3'd0: p = 14'b10101000000000;
      3'd1: p = 14'b11100000000000;
      3'd2: p = 14'b10101110000000;
      3'd3: p = 14'b10101011100000;
      3'd4: p = 14'b10111011100000;
      3'd5: p = 14'b11101010111000;
      3'd6: p = 14'b11101011101110;
      3'd7: p = 14'b11101110101000;
      default: p = '0;
    endcase
    return p;
  endfunction

  // Ready looks only at the registered count, so a pop in the same cycle never frees a slot early.
  assign req_ready       = (r_count != COUNT_FULL);
  assign w_push          = req_valid && req_ready && !w_abort;
  assign w_pop           = (r_state == ST_LOAD);
  assign w_fifo_nonempty = (r_count != '0);
  assign w_head          = r_mem[r_rd_ptr];

  assign w_tick     = ((r_state == ST_SHIFT) || (r_state == ST_GAP)) && (r_tick_cnt == '0);
  assign w_last_bit = (r_state == ST_SHIFT) && w_tick && (r_bit_cnt == 4'd1);
  assign w_last_gap = (r_state == ST_GAP) && w_tick && (r_gap_cnt == GW'(1));

  // Pulses during the final cycle of a letter, so the following cycle is LOAD or IDLE.
  assign letter_done = !w_abort && (w_last_gap || (w_last_bit && (GAP_BITS == 0)));
  assign morse_out   = (r_state == ST_SHIFT) && r_shift[13];
  assign busy        = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= req_letter;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_tick_cnt <= TICK_RELOAD;
    end else if (w_abort) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_tick_cnt <= TICK_RELOAD;
    end else begin
      if (w_tick || (r_state == ST_LOAD)) begin
        r_tick_cnt <= TICK_RELOAD;
      end else if ((r_state == ST_SHIFT) || (r_state == ST_GAP)) begin
        r_tick_cnt <= r_tick_cnt - CW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_fifo_nonempty) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_shift   <= pattern_of(w_head);
          r_bit_cnt <= 4'd14;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_tick) begin
            r_shift   <= {r_shift[12:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 4'd1;
            if (r_bit_cnt == 4'd1) begin
              if (GAP_BITS > 0) begin
                r_state   <= ST_GAP;
                r_gap_cnt <= GAP_LOAD;
              end else begin
                r_state <= w_fifo_nonempty ? ST_LOAD : ST_IDLE;
              end
            end
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
            if (r_gap_cnt == GW'(1)) begin
              r_state <= w_fifo_nonempty ? ST_LOAD : ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
